// File: rtl/ts_mem_pkg.sv
// Shared types and constants for the TS2068 single-port SRAM arbiter.
package ts_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PID_VID = 2'd0,
    PID_CPU = 2'd1,
    PID_LDR = 2'd2
  } port_id_t;

  localparam int         VOFF_W    = 14;
  localparam logic [7:0] CPU_Q_RST = 8'hFF;

endpackage

// File: rtl/ts_mem_arb_if.sv
// Requester and SRAM pin bundle for ts_mem_arb; loader signals exist only
// when TS_MEM_ARB_LOADER_EN is defined.
interface ts_mem_arb_if
  import ts_mem_pkg::*;
#(
  parameter int AW = 21
);
  logic              vReq;
  logic              vBank;
  logic [VOFF_W-1:0] vA;
  logic              vAck;
  logic [7:0]        vQ;
  logic [AW-1:0]     cpuA;
  logic [7:0]        cpuD;
  logic              cpuR;
  logic              cpuW;
  logic              cpuAck;
  logic [7:0]        cpuQ;
`ifdef TS_MEM_ARB_LOADER_EN
  logic [AW-1:0]     ldA;
  logic [7:0]        ldD;
  logic              ldReq;
  logic              ldAck;
`endif
  logic [AW-1:0]     sramA;
  logic [7:0]        sramD;
  logic [7:0]        sramQ;
  logic              sramOe_n;
  logic              sramWe_n;

`ifdef TS_MEM_ARB_LOADER_EN
  modport master (
    output vReq, vBank, vA, cpuA, cpuD, cpuR, cpuW, ldA, ldD, ldReq, sramQ,
    input  vAck, vQ, cpuAck, cpuQ, ldAck, sramA, sramD, sramOe_n, sramWe_n
  );
  modport slave (
    input  vReq, vBank, vA, cpuA, cpuD, cpuR, cpuW, ldA, ldD, ldReq, sramQ,
    output vAck, vQ, cpuAck, cpuQ, ldAck, sramA, sramD, sramOe_n, sramWe_n
  );
`else
  modport master (
    output vReq, vBank, vA, cpuA, cpuD, cpuR, cpuW, sramQ,
    input  vAck, vQ, cpuAck, cpuQ, sramA, sramD, sramOe_n, sramWe_n
  );
  modport slave (
    input  vReq, vBank, vA, cpuA, cpuD, cpuR, cpuW, sramQ,
    output vAck, vQ, cpuAck, cpuQ, sramA, sramD, sramOe_n, sramWe_n
  );
`endif
endinterface

// File: rtl/ts_mem_arb_port.sv
// One requester's pending flag plus address/data/direction latch. With EDGE
// set, requests are rising edges of the rd/wr strobes; otherwise levels.
module ts_mem_arb_port #(
  parameter int AW   = 21,
  parameter bit EDGE = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    data,
  input  logic          clr,
  output logic          pending_r,
  output logic [AW-1:0] addr_r,
  output logic [7:0]    data_r,
  output logic          wr_r
);
  logic rd_prev_r;
  logic wr_prev_r;
  logic cap_s;
  logic cap_wr_s;

  // Capture qualifier; a write wins if both strobes rise together.
  always_comb begin
    cap_s    = 1'b0;
    cap_wr_s = 1'b0;
    if (EDGE) begin
      cap_wr_s = req_wr & ~wr_prev_r;
      cap_s    = (req_rd & ~rd_prev_r) | cap_wr_s;
    end else begin
      cap_wr_s = req_wr;
      cap_s    = req_rd | req_wr;
    end
  end

  // Pending flag and request latch; clear has priority so a capture on the
  // clearing edge is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_prev_r <= 1'b0;
      wr_prev_r <= 1'b0;
      pending_r <= 1'b0;
      addr_r    <= '0;
      data_r    <= 8'h00;
      wr_r      <= 1'b0;
    end else begin
      rd_prev_r <= req_rd;
      wr_prev_r <= req_wr;
      if (clr) begin
        pending_r <= 1'b0;
      end else if (cap_s && !pending_r) begin
        pending_r <= 1'b1;
        addr_r    <= addr;
        data_r    <= data;
        wr_r      <= cap_wr_s;
      end
    end
  end
endmodule

// File: rtl/ts_mem_arb.sv
// Fixed-priority (video > cpu > loader) arbiter for one asynchronous SRAM.
// Loader port is built only when TS_MEM_ARB_LOADER_EN is defined.
module ts_mem_arb
  import ts_mem_pkg::*;
#(
  parameter int            AW    = 21,
  parameter int            ACC   = 2,
  parameter logic [AW-16:0] VBASE = '0
) (
  input logic         clock,
  input logic         reset,
  ts_mem_arb_if.slave bus
);
  localparam logic [2:0] ACC_LAST = 3'(ACC - 1);

  state_t        state_r, state_s;
  port_id_t      grant_r, grant_s;
  logic          start_s, finish_s;
  logic [2:0]    cnt_r;
  logic          wr_r;
  logic [AW-1:0] sram_a_r;
  logic [7:0]    sram_d_r, v_q_r, cpu_q_r;
  logic          oe_n_r, we_n_r, v_ack_r, cpu_ack_r;
  logic [AW-1:0] sel_addr_s;
  logic [7:0]    sel_data_s;
  logic          sel_wr_s;

  logic          vid_pend, vid_wr, cpu_pend, cpu_wr;
  logic [AW-1:0] vid_addr, cpu_addr;
  logic [7:0]    vid_data, cpu_data;

  ts_mem_arb_port #(.AW(AW), .EDGE(1'b0)) u_vid (
    .clock(clock), .reset(reset), .req_rd(bus.vReq), .req_wr(1'b0),
    .addr({VBASE, bus.vBank, bus.vA}), .data(8'h00),
    .clr(state_r == ST_DONE && grant_r == PID_VID),
    .pending_r(vid_pend), .addr_r(vid_addr), .data_r(vid_data), .wr_r(vid_wr)
  );

  ts_mem_arb_port #(.AW(AW), .EDGE(1'b1)) u_cpu (
    .clock(clock), .reset(reset), .req_rd(bus.cpuR), .req_wr(bus.cpuW),
    .addr(bus.cpuA), .data(bus.cpuD),
    .clr(state_r == ST_DONE && grant_r == PID_CPU),
    .pending_r(cpu_pend), .addr_r(cpu_addr), .data_r(cpu_data), .wr_r(cpu_wr)
  );

`ifdef TS_MEM_ARB_LOADER_EN
  logic          ld_pend, ld_wr, ld_ack_r;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;

  ts_mem_arb_port #(.AW(AW), .EDGE(1'b0)) u_ldr (
    .clock(clock), .reset(reset), .req_rd(1'b0), .req_wr(bus.ldReq),
    .addr(bus.ldA), .data(bus.ldD),
    .clr(state_r == ST_DONE && grant_r == PID_LDR),
    .pending_r(ld_pend), .addr_r(ld_addr), .data_r(ld_data), .wr_r(ld_wr)
  );
  assign bus.ldAck = ld_ack_r;
`endif

  // Next state and grant selection.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    start_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vid_pend) begin
          grant_s = PID_VID;
          start_s = 1'b1;
          state_s = ST_ACCESS;
        end else if (cpu_pend) begin
          grant_s = PID_CPU;
          start_s = 1'b1;
          state_s = ST_ACCESS;
`ifdef TS_MEM_ARB_LOADER_EN
        end else if (ld_pend) begin
          grant_s = PID_LDR;
          start_s = 1'b1;
          state_s = ST_ACCESS;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == ACC_LAST) begin
          finish_s = 1'b1;
          state_s  = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request mux for the port being granted this cycle.
  always_comb begin
    sel_addr_s = vid_addr;
    sel_data_s = vid_data;
    sel_wr_s   = vid_wr;
    case (grant_s)
      PID_VID: begin
        sel_addr_s = vid_addr;
        sel_data_s = vid_data;
        sel_wr_s   = vid_wr;
      end
      PID_CPU: begin
        sel_addr_s = cpu_addr;
        sel_data_s = cpu_data;
        sel_wr_s   = cpu_wr;
      end
`ifdef TS_MEM_ARB_LOADER_EN
      PID_LDR: begin
        sel_addr_s = ld_addr;
        sel_data_s = ld_data;
        sel_wr_s   = ld_wr;
      end
`endif
      default: begin
        sel_addr_s = vid_addr;
        sel_data_s = vid_data;
        sel_wr_s   = vid_wr;
      end
    endcase
  end

  // SRAM sequencing, read-data capture and ack pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      grant_r   <= PID_VID;
      cnt_r     <= 3'd0;
      wr_r      <= 1'b0;
      sram_a_r  <= '0;
      sram_d_r  <= 8'h00;
      oe_n_r    <= 1'b1;
      we_n_r    <= 1'b1;
      v_q_r     <= 8'h00;
      cpu_q_r   <= CPU_Q_RST;
      v_ack_r   <= 1'b0;
      cpu_ack_r <= 1'b0;
`ifdef TS_MEM_ARB_LOADER_EN
      ld_ack_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      v_ack_r   <= finish_s && (grant_r == PID_VID);
      cpu_ack_r <= finish_s && (grant_r == PID_CPU);
`ifdef TS_MEM_ARB_LOADER_EN
      ld_ack_r  <= finish_s && (grant_r == PID_LDR);
`endif
      if (start_s) begin
        cnt_r    <= 3'd0;
        wr_r     <= sel_wr_s;
        sram_a_r <= sel_addr_s;
        sram_d_r <= sel_wr_s ? sel_data_s : 8'h00;
        oe_n_r   <= sel_wr_s;
        we_n_r   <= ~sel_wr_s;
      end else if (finish_s) begin
        oe_n_r <= 1'b1;
        we_n_r <= 1'b1;
        if (!wr_r) begin
          case (grant_r)
            PID_VID: v_q_r   <= bus.sramQ;
            PID_CPU: cpu_q_r <= bus.sramQ;
            default: ;
          endcase
        end
      end else if (state_r == ST_ACCESS) begin
        cnt_r <= cnt_r + 3'd1;
      end
    end
  end

  assign bus.sramA    = sram_a_r;
  assign bus.sramD    = sram_d_r;
  assign bus.sramOe_n = oe_n_r;
  assign bus.sramWe_n = we_n_r;
  assign bus.vQ       = v_q_r;
  assign bus.vAck     = v_ack_r;
  assign bus.cpuQ     = cpu_q_r;
  assign bus.cpuAck   = cpu_ack_r;
endmodule
